// File: rtl/mem_io_bridge_pkg.sv
// mem_io_bridge_pkg
//   Shared definitions for the MEM-stage load/store bridge: the default IO window base,
//   board channel indices, FSM state encoding and the bus-error read pattern.
//   Optional feature macro used by mem_io_bridge: MEMIO_BUSERR_EN.
package mem_io_bridge_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;

    // Input channel indices (word index inside the IO window)
    localparam int CH_SWITCH = 0;
    localparam int CH_KEY    = 1;
    localparam int CH_BTN    = 2;

    // Output channel indices (relative to the first output word, N_IN)
    localparam int CH_LED    = 0;
    localparam int CH_SEG    = 1;

    // Load data returned for unmapped IO words when bus errors are enabled
    localparam logic [31:0] BUSERR_PATTERN = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // The IO window is 1 KiB aligned, so only address bits [31:10] select it.
    function automatic logic io_window_hit(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:10] == base[31:10];
    endfunction

endpackage

// File: rtl/mem_io_bridge_io_in_sync.sv
// io_in_sync
//   Two-flop synchroniser for one asynchronous board input channel.
// Ports
//   clk  in   1       system clock
//   rst  in   1       synchronous active-high reset, clears both stages
//   d    in   WIDTH   raw asynchronous input
//   q    out  WIDTH   synchronised value (two clk edges after d changes)
module io_in_sync #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge
//   MEM-stage load/store bridge between the pipeline, data memory and board IO.
//   Requests use a valid/ready handshake; data-memory loads wait MEM_RD_LAT cycles,
//   stores and IO loads respond on the following cycle without leaving IDLE so the
//   pipeline can issue back to back.
//   Optional feature: define MEMIO_BUSERR_EN to flag unmapped IO accesses on rsp_err
//   and return BUSERR_PATTERN for unmapped loads (otherwise rsp_err is 0 and loads read 0).
//
//   state   | meaning
//   IDLE    | ready for a request; stores and IO loads complete from here
//   WAIT    | data-memory read in flight, cnt counts down to capture
//   RESP    | presenting the captured load data
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/ready/wr       request handshake and direction (1 = store)
//   req_addr, req_wdata      byte address and store data
//   rsp_valid/rdata/err      one-cycle response, load data, unmapped-IO flag
//   mem_addr/re/we/wdata     data-memory interface, m_rdata read data
//   in_data                  N_IN raw input channels, 32 bits each
//   out_data, out_strobe     N_OUT output latches and their write pulses
module mem_io_bridge
    import mem_io_bridge_pkg::*;
#(
    parameter int          N_IN       = 3,
    parameter int          N_OUT      = 2,
    parameter int          MEM_RD_LAT = 1,
    parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [31:0]           mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           m_rdata,
    input  logic [32*N_IN-1:0]    in_data,
    output logic [32*N_OUT-1:0]   out_data,
    output logic [N_OUT-1:0]      out_strobe
);

`ifdef MEMIO_BUSERR_EN
    localparam logic        BUSERR_EN      = 1'b1;
    localparam logic [31:0] UNMAPPED_RDATA = BUSERR_PATTERN;
`else
    localparam logic        BUSERR_EN      = 1'b0;
    localparam logic [31:0] UNMAPPED_RDATA = 32'h0;
`endif

    localparam logic [3:0] CNT_LOAD = 4'(MEM_RD_LAT);

    state_t                  state;
    logic [3:0]              cnt;
    logic [31:0]             addr_q;
    logic                    err_q;
    logic [N_OUT-1:0][31:0]  out_reg;
    logic [N_IN-1:0][31:0]   in_sync;

    logic                    accept;
    logic                    is_io;
    logic [7:0]              idx;
    logic [31:0]             io_rd_data;
    logic                    io_rd_hit;
    logic [N_OUT-1:0]        io_wr_sel;

    for (genvar g = 0; g < N_IN; g++) begin : g_in_sync
        io_in_sync #(.WIDTH(32)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (in_data[32*g +: 32]),
            .q   (in_sync[g])
        );
    end

    // Address decode of the presented request
    always_comb begin
        is_io      = io_window_hit(req_addr, IO_BASE);
        idx        = req_addr[9:2];
        io_rd_data = '0;
        io_rd_hit  = 1'b0;
        io_wr_sel  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (idx == 8'(i)) begin
                io_rd_data = in_sync[i];
                io_rd_hit  = 1'b1;
            end
        end
        for (int i = 0; i < N_OUT; i++) begin
            if (idx == 8'(N_IN + i)) begin
                io_rd_data   = out_reg[i];
                io_rd_hit    = 1'b1;
                io_wr_sel[i] = 1'b1;
            end
        end
    end

    assign accept = req_valid & req_ready;

    // The dMem strobes must coincide with the accept cycle, so they are decoded
    // directly from the handshake rather than registered.
    assign mem_re    = accept & ~is_io & ~req_wr;
    assign mem_we    = accept & ~is_io &  req_wr;
    assign mem_wdata = req_wdata;
    assign mem_addr  = (state == ST_IDLE) ? req_addr : addr_q;

    assign out_data  = out_reg;
    assign rsp_err   = err_q & BUSERR_EN;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            cnt        <= '0;
            addr_q     <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            err_q      <= 1'b0;
            out_reg    <= '0;
            out_strobe <= '0;
        end else begin
            rsp_valid  <= 1'b0;
            err_q      <= 1'b0;
            out_strobe <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q <= req_addr;
                        if (!is_io && !req_wr) begin
                            state     <= ST_WAIT;
                            req_ready <= 1'b0;
                            cnt       <= CNT_LOAD;
                        end else begin
                            rsp_valid <= 1'b1;
                            if (req_wr) begin
                                rsp_rdata <= '0;
                                if (is_io) begin
                                    for (int i = 0; i < N_OUT; i++) begin
                                        if (io_wr_sel[i]) begin
                                            out_reg[i] <= req_wdata;
                                        end
                                    end
                                    out_strobe <= io_wr_sel;
                                    err_q      <= ~(|io_wr_sel);
                                end
                            end else begin
                                rsp_rdata <= io_rd_hit ? io_rd_data : UNMAPPED_RDATA;
                                err_q     <= ~io_rd_hit;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    // cnt == 1 is the cycle in which dMem data is valid
                    if (cnt == 4'd1) begin
                        rsp_rdata <= m_rdata;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
module tb_mem_io_bridge;
    import mem_io_bridge_pkg::*;

    localparam int N_IN  = 3;
    localparam int N_OUT = 2;
    localparam int LAT   = 3;

`ifdef MEMIO_BUSERR_EN
    localparam logic [31:0] EXP_UNMAP_RD  = 32'hDEAD_BEEF;
    localparam logic        EXP_UNMAP_ERR = 1'b1;
`else
    localparam logic [31:0] EXP_UNMAP_RD  = 32'h0;
    localparam logic        EXP_UNMAP_ERR = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic [31:0]           mem_addr;
    logic                  mem_re;
    logic                  mem_we;
    logic [31:0]           mem_wdata;
    logic [31:0]           m_rdata;
    logic [32*N_IN-1:0]    in_data;
    logic [32*N_OUT-1:0]   out_data;
    logic [N_OUT-1:0]      out_strobe;

    mem_io_bridge #(
        .N_IN       (N_IN),
        .N_OUT      (N_OUT),
        .MEM_RD_LAT (LAT),
        .IO_BASE    (32'hFFFF_FC00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .m_rdata    (m_rdata),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_strobe (out_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // ---------------- data memory model with fixed read latency ----------------
    logic [31:0] mem_arr [64];
    logic        mem_wflag [64];
    logic        pv [1:LAT];
    logic [31:0] pa [1:LAT];
    logic [31:0] rd_a;

    function automatic logic [31:0] default_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h1234_5678;
        return {16'h5A00, a[15:0]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= LAT; k++) pv[k] <= 1'b0;
            for (int k = 0; k < 64; k++) mem_wflag[k] <= 1'b0;
        end else begin
            pv[1] <= mem_re;
            pa[1] <= mem_addr;
            for (int k = 2; k <= LAT; k++) begin
                pv[k] <= pv[k-1];
                pa[k] <= pa[k-1];
            end
            if (mem_we) begin
                mem_arr[mem_wdata_idx()]   <= mem_wdata;
                mem_wflag[mem_wdata_idx()] <= 1'b1;
            end
        end
    end

    function automatic int mem_wdata_idx();
        logic [31:0] a;
        a = mem_addr;
        return int'(a[7:2]);
    endfunction

    assign rd_a = pa[LAT];
    always_comb begin
        m_rdata = 32'hBAD0_BAD0;
        if (pv[LAT]) m_rdata = mem_wflag[rd_a[7:2]] ? mem_arr[rd_a[7:2]] : default_word(rd_a);
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected rsp_valid", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp cycle", 64'(cyc), 64'(mon_e.cyc));
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
                check("rsp_err", rsp_err, mon_e.err);
            end
        end
    end

    function automatic logic is_io_addr(input logic [31:0] a);
        return (a & 32'hFFFF_FC00) == 32'hFFFF_FC00;
    endfunction

    // Present a request from posedge+1, wait for acceptance, check the dMem strobes
    // in the accept cycle and push the expected response. Returns at posedge+1 after accept.
    task automatic issue(input string name, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic push,
                         input logic [31:0] exp_rdata, input logic exp_err);
        int   t_acc;
        logic io;
        io        = is_io_addr(addr);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        t_acc     = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_ready) begin
                t_acc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        if (t_acc < 0) begin
            check({name, " accept timeout"}, 0, 1);
        end else begin
            check({name, " mem_re"}, mem_re, !io && !wr);
            check({name, " mem_we"}, mem_we, !io && wr);
            check({name, " mem_addr"}, mem_addr, addr);
            if (!io && wr) check({name, " mem_wdata"}, mem_wdata, wdata);
            if (push) sb_q.push_back('{t_acc + ((io || wr) ? 1 : 1 + LAT), exp_rdata, exp_err});
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check("responses drained", 64'(sb_q.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, req_ready, 1);
        check({tag, " rsp_valid"}, rsp_valid, 0);
        check({tag, " rsp_err"}, rsp_err, 0);
        check({tag, " mem_re"}, mem_re, 0);
        check({tag, " mem_we"}, mem_we, 0);
        check({tag, " out_strobe"}, 64'(out_strobe), 0);
        check({tag, " out_data"}, 64'(out_data), 0);
        check({tag, " rsp_rdata"}, rsp_rdata, 0);
    endtask

    logic seen;
    localparam logic [31:0] A_LED = 32'hFFFF_FC00 + 32'(4 * (N_IN + CH_LED));
    localparam logic [31:0] A_SEG = 32'hFFFF_FC00 + 32'(4 * (N_IN + CH_SEG));
    localparam logic [31:0] A_SW  = 32'hFFFF_FC00 + 32'(4 * CH_SWITCH);
    localparam logic [31:0] A_KEY = 32'hFFFF_FC00 + 32'(4 * CH_KEY);
    localparam logic [31:0] A_BTN = 32'hFFFF_FC00 + 32'(4 * CH_BTN);

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        in_data   = {32'h0000_0333, 32'h0000_0222, 32'h0000_0111};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1;

        // Reset in the middle of a pending dMem read: no response may appear
        issue("ld_abort", 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_wait_rst");
        @(posedge clk); #1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("no rsp after aborted read", seen, 0);

        // dMem load with latency 3
        issue("ld_mem10", 1'b0, 32'h10, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            check($sformatf("ld_mem10 req_ready T+%0d", k), req_ready, 0);
            check($sformatf("ld_mem10 mem_re T+%0d", k), mem_re, 0);
            check($sformatf("ld_mem10 mem_addr T+%0d", k), mem_addr, 32'h10);
            @(posedge clk); #1;
        end
        drain();

        // Output latches: store, strobe, readback
        issue("st_led", 1'b1, A_LED, 32'h0000_00A5, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        check("st_led out_data[31:0]", out_data[31:0], 32'hA5);
        check("st_led out_strobe", 64'(out_strobe), 2'b01);
        @(posedge clk); #1;
        issue("ld_led", 1'b0, A_LED, 32'h0, 1'b1, 32'h0000_00A5, 1'b0);
        issue("st_seg", 1'b1, A_SEG, 32'h0000_1234, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        check("st_seg out_data[63:32]", out_data[63:32], 32'h1234);
        check("st_seg out_strobe", 64'(out_strobe), 2'b10);
        check("st_seg led kept", out_data[31:0], 32'hA5);
        @(posedge clk); #1;
        issue("ld_seg", 1'b0, A_SEG, 32'h0, 1'b1, 32'h0000_1234, 1'b0);
        drain();

        // Synchronised inputs
        issue("ld_key", 1'b0, A_KEY, 32'h0, 1'b1, 32'h0000_0222, 1'b0);
        issue("ld_btn", 1'b0, A_BTN, 32'h0, 1'b1, 32'h0000_0333, 1'b0);
        in_data[31:0] = 32'h0000_0ABC;
        @(posedge clk); #1;
        issue("ld_sw T",   1'b0, A_SW, 32'h0, 1'b1, 32'h0000_0111, 1'b0);
        issue("ld_sw T+1", 1'b0, A_SW, 32'h0, 1'b1, 32'h0000_0ABC, 1'b0);
        issue("ld_sw T+2", 1'b0, A_SW, 32'h0, 1'b1, 32'h0000_0ABC, 1'b0);
        drain();

        // Unmapped IO words and the window boundary
        issue("ld_idx16", 1'b0, 32'hFFFF_FC40, 32'h0, 1'b1, EXP_UNMAP_RD, EXP_UNMAP_ERR);
        issue("ld_idx255", 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, EXP_UNMAP_RD, EXP_UNMAP_ERR);
        issue("st_input", 1'b1, A_SW, 32'h0000_FFFF, 1'b1, 32'h0, EXP_UNMAP_ERR);
        @(negedge clk);
        check("st_input out_strobe", 64'(out_strobe), 0);
        check("st_input out_data", 64'(out_data), {32'h1234, 32'hA5});
        @(posedge clk); #1;
        issue("ld_below_io", 1'b0, 32'hFFFF_FBFC, 32'h0, 1'b1, 32'h5A00_FBFC, 1'b0);
        drain();

        // Back-to-back store then load of the same dMem word, request held valid
        issue("st_mem20", 1'b1, 32'h20, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0);
        issue("ld_mem20", 1'b0, 32'h20, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
        drain();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rsp_rdata held", rsp_rdata, 32'hCAFE_F00D);
        check("rsp_valid idle", rsp_valid, 0);

        check("scoreboard empty", 64'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

endmodule
